// File: rtl/i2s_dac_tx.sv
// Stereo I2S transmitter: per-channel sample FIFOs serialised MSB-first onto AUD_DACDAT,
// framed by the codec-mastered AUD_BCLK/AUD_DACLRCK which are oversampled on clk.
`timescale 1ns/1ps
module i2s_dac_tx #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned SAMPLE_BITS = 24,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] left_data,
    input  logic                  left_valid,
    output logic                  left_ready,
    input  logic [DATA_WIDTH-1:0] right_data,
    input  logic                  right_valid,
    output logic                  right_ready,
    input  logic                  AUD_BCLK,
    input  logic                  AUD_DACLRCK,
    output logic                  AUD_DACDAT,
    output logic                  underflow_l,
    output logic                  underflow_r
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = (SAMPLE_BITS > 1) ? $clog2(SAMPLE_BITS) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DELAY = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_PAD   = 2'd3;

    // Pin synchronisers: [0],[1] metastability stages, bclk [2] is the edge history.
    logic [2:0] bclk_sync_q, bclk_sync_d;
    logic [1:0] lrck_sync_q, lrck_sync_d;
    logic       lrck_prev_q, lrck_prev_d;
    logic       bfall, lrck_now, lrc_edge;

    // Channel-indexed FIFO storage: index 0 = left, 1 = right.
    logic [1:0]             valid, push, pop;
    logic [1:0]             ready_q, ready_d;
    logic [SAMPLE_BITS-1:0] wdata [2];
    logic [SAMPLE_BITS-1:0] head  [2];
    logic [SAMPLE_BITS-1:0] mem_q [2][FIFO_DEPTH];
    logic [PTR_W-1:0]       wptr_q [2], wptr_d [2];
    logic [PTR_W-1:0]       rptr_q [2], rptr_d [2];
    logic [PTR_W:0]         count_q [2], count_d [2];

    logic [1:0]             state_q, state_d;
    logic                   chan_q, chan_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SAMPLE_BITS-1:0] shreg_q, shreg_d;
    logic [SAMPLE_BITS-1:0] word;
    logic                   dacdat_q, dacdat_d;
    logic [1:0]             uf_q, uf_d;

    assign bclk_sync_d = {bclk_sync_q[1:0], AUD_BCLK};
    assign lrck_sync_d = {lrck_sync_q[0], AUD_DACLRCK};
    assign bfall       = bclk_sync_q[2] & ~bclk_sync_q[1];
    assign lrck_now    = lrck_sync_q[1];
    assign lrc_edge    = lrck_now != lrck_prev_q;

    assign valid    = {right_valid, left_valid};
    assign wdata[0] = left_data[SAMPLE_BITS-1:0];
    assign wdata[1] = right_data[SAMPLE_BITS-1:0];
    assign push     = valid & ready_q;

    generate
        if (DATA_WIDTH > SAMPLE_BITS) begin : g_unused_hi
            logic unused_hi;
            assign unused_hi = ^{left_data[DATA_WIDTH-1:SAMPLE_BITS],
                                 right_data[DATA_WIDTH-1:SAMPLE_BITS]};
        end
    endgenerate

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            head[c]    = mem_q[c][rptr_q[c]];
            wptr_d[c]  = wptr_q[c];
            rptr_d[c]  = rptr_q[c];
            if (push[c]) wptr_d[c] = wptr_q[c] + PTR_W'(1);
            if (pop[c])  rptr_d[c] = rptr_q[c] + PTR_W'(1);
            count_d[c] = count_q[c] + (PTR_W + 1)'(push[c]) - (PTR_W + 1)'(pop[c]);
            // Ready follows the registered count, so a pop never frees a slot same-cycle.
            ready_d[c] = count_d[c] != FULL_CNT;
        end
    end

    always_comb begin
        state_d     = state_q;
        chan_d      = chan_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        dacdat_d    = dacdat_q;
        lrck_prev_d = lrck_prev_q;
        uf_d        = 2'b00;
        pop         = 2'b00;
        word        = '0;
        if (bfall) begin
            lrck_prev_d = lrck_now;
            case (state_q)
                ST_IDLE: begin
                    dacdat_d = 1'b0;
                    if (lrc_edge && !lrck_now) begin
                        state_d = ST_DELAY;
                        chan_d  = 1'b0;
                    end
                end
                ST_DELAY: begin
                    if (count_q[chan_q] != '0) begin
                        pop[chan_q] = 1'b1;
                        word        = head[chan_q];
                    end else begin
                        uf_d[chan_q] = 1'b1;
                    end
                    dacdat_d = word[SAMPLE_BITS-1];
                    shreg_d  = word << 1;
                    cnt_d    = CNT_W'(SAMPLE_BITS - 1);
                    state_d  = ST_SHIFT;
                end
                default: begin
                    if (lrc_edge) begin
                        // New half-frame: any unsent LSBs of a short frame are dropped.
                        state_d  = ST_DELAY;
                        chan_d   = lrck_now;
                        dacdat_d = 1'b0;
                    end else if (state_q == ST_SHIFT && cnt_q != '0) begin
                        dacdat_d = shreg_q[SAMPLE_BITS-1];
                        shreg_d  = shreg_q << 1;
                        cnt_d    = cnt_q - CNT_W'(1);
                    end else begin
                        state_d  = ST_PAD;
                        dacdat_d = 1'b0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bclk_sync_q <= '0;
            lrck_sync_q <= '0;
            lrck_prev_q <= 1'b0;
            ready_q     <= 2'b00;
            for (int c = 0; c < 2; c++) begin
                wptr_q[c]  <= '0;
                rptr_q[c]  <= '0;
                count_q[c] <= '0;
            end
            state_q  <= ST_IDLE;
            chan_q   <= 1'b0;
            cnt_q    <= '0;
            shreg_q  <= '0;
            dacdat_q <= 1'b0;
            uf_q     <= 2'b00;
        end else begin
            bclk_sync_q <= bclk_sync_d;
            lrck_sync_q <= lrck_sync_d;
            lrck_prev_q <= lrck_prev_d;
            ready_q     <= ready_d;
            for (int c = 0; c < 2; c++) begin
                wptr_q[c]  <= wptr_d[c];
                rptr_q[c]  <= rptr_d[c];
                count_q[c] <= count_d[c];
            end
            state_q  <= state_d;
            chan_q   <= chan_d;
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
            dacdat_q <= dacdat_d;
            uf_q     <= uf_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (push[c]) mem_q[c][wptr_q[c]] <= wdata[c];
        end
    end

    assign left_ready  = ready_q[0];
    assign right_ready = ready_q[1];
    assign AUD_DACDAT  = dacdat_q;
    assign underflow_l = uf_q[0];
    assign underflow_r = uf_q[1];

endmodule
